// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: read-side master that sweeps the 32x32 register file
// over an inclusive, wrapping address range and streams each word out with
// its address on a valid/ready interface.
// Optional build macro: REGFILE_DUMP_CHECKSUM_EN adds a running XOR checksum
// output of every word handed to the consumer.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              rf_we,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef REGFILE_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end_addr;
  logic [ADDR_W-1:0] r_raddr;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid;
  logic              r_busy;
  logic              w_accept;
  logic              w_capture;
  logic              w_xfer;
  logic              w_last;
  logic              w_done;
  logic [ADDR_W-1:0] w_cur_inc;

  // Wrap-around increment is natural: the sum is truncated to ADDR_W bits.
  assign w_cur_inc = r_cur + ADDR_W'(1);
  assign w_last    = (r_cur == r_end_addr);

  // Next-state decode and per-state control strobes.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // Read data floats while the datapath writes; wait it out.
        if (!rf_we) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = w_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Address sweep, word capture and output handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur       <= '0;
      r_end_addr  <= '0;
      r_raddr     <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur      <= first_addr;
        r_end_addr <= last_addr;
        r_raddr    <= first_addr;
        r_busy     <= 1'b1;
      end
      if (w_capture) begin
        r_out_data  <= rf_rdata;
        r_out_addr  <= r_cur;
        r_out_valid <= 1'b1;
      end
      if (w_xfer) begin
        r_out_valid <= 1'b0;
        if (!w_last) begin
          r_cur   <= w_cur_inc;
          r_raddr <= w_cur_inc;
        end
      end
      if (r_state == S_DONE) r_busy <= 1'b0;
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Running XOR of every word the consumer accepts; held after the dump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_checksum <= '0;
    else if (w_accept) r_checksum <= '0;
    else if (w_xfer)   r_checksum <= r_checksum ^ r_out_data;
  end

  assign checksum = r_checksum;
`endif

  assign rf_raddr  = r_raddr;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = w_done;

endmodule
